// File: rtl/wb_master_engine.sv
// Wishbone classic initiator: one valid/ready command becomes one bus cycle, and the result is returned on a valid/ready response port.
// Optional abort of cycles that are never acknowledged: define WB_MASTER_TIMEOUT_EN.
module wb_master_engine #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int AW             = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [31:0]   cmd_dat,
  input  logic [3:0]    cmd_sel,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_dat,
  output logic          rsp_err,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [3:0]    wbm_sel_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  input  logic [31:0]   wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  logic tmo_hit;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  assign tmo_hit = (state == BUS) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Counts BUS cycles without ack/err; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset || state != BUS)
      tmo_cnt <= '0;
    else if (!wbm_ack_i && !wbm_err_i && !tmo_hit && tmo_cnt < CW'(TIMEOUT_CYCLES))
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          wbm_we_o  <= cmd_we;
          wbm_adr_o <= cmd_adr;
          wbm_dat_o <= cmd_dat;
          wbm_sel_o <= cmd_sel;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          state     <= BUS;
        end
        // CYC/STB drop on the edge that samples ack so a one-cycle ack pulse
        // from a registered slave can never complete a second transfer.
        BUS: if (wbm_ack_i) begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end else if (wbm_err_i || tmo_hit) begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          rsp_dat   <= 32'h0;
          rsp_err   <= 1'b1;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine, with a behavioural Wishbone slave whose response is selected by 'mode'.
module tb_wb_master_engine;

  localparam int AW = 32;
  localparam int M_CNT = 0, M_DATA = 1, M_ERR = 2, M_BOTH = 3, M_DEAD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [31:0]   cmd_dat = '0;
  logic [3:0]    cmd_sel = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0]   rsp_dat;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [31:0]   wbm_dat_o, wbm_dat_i;
  logic          wbm_ack_i, wbm_err_i, busy;

  logic          s_ack = 1'b0, s_err = 1'b0, late_ack = 1'b0;
  logic [31:0]   s_dat = '0, cnt_reg = '0;
  int            mode = M_CNT;
  int            ack_cnt = 0;
  int            n_chk = 0, n_fail = 0;
  logic          bus_we;
  logic [AW-1:0] bus_adr;
  logic [31:0]   bus_dat;
  logic [3:0]    bus_sel;

  assign wbm_ack_i = s_ack | late_ack;
  assign wbm_err_i = s_err;
  assign wbm_dat_i = s_dat;

  always #5 clk = ~clk;

  wb_master_engine #(.TIMEOUT_CYCLES(8), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .busy(busy)
  );

  // Registered slave: answers one cycle after it sees CYC&STB.
  always @(posedge clk) begin
    if (reset) begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
    end else if (wbm_cyc_o && wbm_stb_o && !s_ack && !s_err && mode != M_DEAD) begin
      s_ack <= (mode != M_ERR);
      s_err <= (mode == M_ERR || mode == M_BOTH);
      s_dat <= 32'h1234_5678;
      if (mode == M_DATA) s_dat <= 32'hCAFE_F00D;
      if (mode == M_CNT) begin
        if (wbm_we_o) begin
          cnt_reg <= wbm_dat_o;
          s_dat   <= 32'h5555_AAAA;
        end else begin
          s_dat   <= cnt_reg;
          cnt_reg <= cnt_reg + 1;
        end
      end
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
    end
  end

  always @(posedge clk) if (wbm_ack_i) ack_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    @(negedge clk);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    bus_we = wbm_we_o; bus_adr = wbm_adr_o; bus_dat = wbm_dat_o; bus_sel = wbm_sel_o;
  endtask

  task automatic wait_rsp(output int cyc_len, output int rdy_hi);
    int n = 0;
    cyc_len = 0; rdy_hi = 0;
    while (!rsp_valid && n < 300) begin
      if (wbm_cyc_o) cyc_len++;
      if (cmd_ready) rdy_hi++;
      @(negedge clk);
      n++;
    end
    chk("rsp_arrived", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    int cl, rh, bad;
    logic [31:0] held;

    repeat (2) @(negedge clk);
    chk("rst_cyc", 32'(wbm_cyc_o), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    reset = 1'b0;

    // Write to counter slave
    mode = M_CNT; ack_cnt = 0;
    issue(1'b1, 32'h3000_0000, 32'h0000_0010, 4'hF);
    chk("wr_we", 32'(bus_we), 1);
    chk("wr_adr", bus_adr, 32'h3000_0000);
    chk("wr_dat", bus_dat, 32'h10);
    chk("wr_sel", 32'(bus_sel), 32'hF);
    wait_rsp(cl, rh);
    chk("wr_cyc_len", cl, 2);
    chk("wr_ack_once", ack_cnt, 1);
    chk("wr_rsp_err", 32'(rsp_err), 0);
    chk("wr_rsp_dat", rsp_dat, 0);
    @(negedge clk);
    chk("wr_idle_after", 32'(cmd_ready), 1);
    chk("wr_cyc_after", 32'(wbm_cyc_o), 0);

    // Counter readback
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    wait_rsp(cl, rh);
    chk("cnt_rd0", rsp_dat, 32'h10);
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    wait_rsp(cl, rh);
    chk("cnt_rd1", rsp_dat, 32'h11);

    // Plain read
    mode = M_DATA;
    issue(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    chk("rd_busy", 32'(busy), 1);
    wait_rsp(cl, rh);
    chk("rd_dat", rsp_dat, 32'hCAFE_F00D);
    chk("rd_err", 32'(rsp_err), 0);
    chk("rd_ready_low", rh, 0);
    chk("rd_ready_resp", 32'(cmd_ready), 0);

    // Backpressure
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    wait_rsp(cl, rh);
    held = rsp_dat;
    chk("bp_dat", held, 32'hCAFE_F00D);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i % 2 == 0);
      @(negedge clk);
      if (!rsp_valid || rsp_dat !== held || cmd_ready || wbm_cyc_o) bad++;
    end
    cmd_valid = 1'b0;
    chk("bp_stable", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle", 32'(cmd_ready), 1);
    chk("bp_rsp_drop", 32'(rsp_valid), 0);
    chk("bp_no_cyc", 32'(wbm_cyc_o), 0);

    // Error and ack/err priority
    mode = M_ERR;
    issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    wait_rsp(cl, rh);
    chk("err_flag", 32'(rsp_err), 1);
    chk("err_dat", rsp_dat, 0);
    mode = M_BOTH;
    issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    wait_rsp(cl, rh);
    chk("both_err", 32'(rsp_err), 0);
    chk("both_dat", rsp_dat, 32'h1234_5678);

    // Dead slave
    mode = M_DEAD;
`ifdef WB_MASTER_TIMEOUT_EN
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    wait_rsp(cl, rh);
    chk("tmo_cyc_len", cl, 8);
    chk("tmo_err", 32'(rsp_err), 1);
    chk("tmo_dat", rsp_dat, 0);
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
`else
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    repeat (100) @(negedge clk);
    chk("notmo_rsp_valid", 32'(rsp_valid), 0);
`endif
    chk("pre_rst_cyc", 32'(wbm_cyc_o), 1);

    // Reset mid-BUS, then a stray ack
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_cyc", 32'(wbm_cyc_o), 0);
    chk("mrst_stb", 32'(wbm_stb_o), 0);
    chk("mrst_rsp_valid", 32'(rsp_valid), 0);
    chk("mrst_cmd_ready", 32'(cmd_ready), 1);
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || busy) bad++;
    end
    chk("late_ack_ignored", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
